// File: rtl/fp_mul_special_pipe_pkg.sv
// Shared floating-point parameters for the special-case multiplier pipeline.
package fp_mul_special_pipe_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_EXP_WIDTH = 8;
    localparam int DEF_SIG_WIDTH = 23;

    // Canonical quiet NaN at the default format: sign 0, exponent all ones,
    // fraction MSB set, remaining fraction bits clear.
    localparam logic [DEF_WIDTH-1:0] CANON_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        CLS_ZERO    = 3'd0,
        CLS_SUBNORM = 3'd1,
        CLS_NORMAL  = 3'd2,
        CLS_INF     = 3'd3,
        CLS_QNAN    = 3'd4,
        CLS_SNAN    = 3'd5
    } fp_class_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: exponent/fraction fields -> class.
module fp_classify
    import fp_mul_special_pipe_pkg::*;
#(
    parameter int EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int SIG_WIDTH = DEF_SIG_WIDTH
) (
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [SIG_WIDTH-1:0] frac,
    output fp_class_e            cls
);

    logic exp_zero;
    logic exp_ones;
    logic frac_zero;

    assign exp_zero  = (exp == '0);
    assign exp_ones  = (exp == '1);
    assign frac_zero = (frac == '0);

    // Decode the class from the field patterns.
    always_comb begin
        cls = CLS_NORMAL;
        if (exp_zero) begin
            cls = frac_zero ? CLS_ZERO : CLS_SUBNORM;
        end else if (exp_ones) begin
            if (frac_zero) begin
                cls = CLS_INF;
            end else if (frac[SIG_WIDTH-1]) begin
                cls = CLS_QNAN;
            end else begin
                cls = CLS_SNAN;
            end
        end
    end

endmodule

// File: rtl/fp_mul_special_pipe.sv
// Two-stage multiplier special-case resolver: stage 1 registers operand
// classes, stage 2 registers the override result; valid/ready on both sides.
module fp_mul_special_pipe
    import fp_mul_special_pipe_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int SIG_WIDTH = DEF_SIG_WIDTH,
    parameter int DAZ       = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 special,
    output logic [WIDTH-1:0]     result,
    output logic                 sign,
    output logic                 nv,
    output logic [1:0]           flags,
    input  logic                 flag_clr,
    output logic [CNT_WIDTH-1:0] special_cnt
);

    // Generic form of CANON_QNAN so non-default formats resolve correctly.
    localparam logic [WIDTH-1:0] QNAN_VAL =
        {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};

    fp_class_e cls_a;
    fp_class_e cls_b;

    fp_classify #(.EXP_WIDTH(EXP_WIDTH), .SIG_WIDTH(SIG_WIDTH)) u_cls_a (
        .exp  (a[WIDTH-2 -: EXP_WIDTH]),
        .frac (a[SIG_WIDTH-1:0]),
        .cls  (cls_a)
    );

    fp_classify #(.EXP_WIDTH(EXP_WIDTH), .SIG_WIDTH(SIG_WIDTH)) u_cls_b (
        .exp  (b[WIDTH-2 -: EXP_WIDTH]),
        .frac (b[SIG_WIDTH-1:0]),
        .cls  (cls_b)
    );

    // Stage 1 state
    logic      s1_valid;
    fp_class_e s1_cls_a;
    fp_class_e s1_cls_b;
    logic      s1_sign;

    // Stage 2 extra state: result is an infinity (feeds the sticky flag)
    logic      out_inf;

    logic s2_adv;
    logic out_fire;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign out_fire = out_valid && out_ready;

    // Resolution of the stage-1 classes
    logic             res_special;
    logic [WIDTH-1:0] res_result;
    logic             res_nv;
    logic             res_inf;
    logic             za, zb, ia, ib, na, nb, sa, sb;

    // Priority: NaN operand, then INF x ZERO, then infinity, then zero.
    always_comb begin
        res_special = 1'b0;
        res_result  = '0;
        res_nv      = 1'b0;
        res_inf     = 1'b0;
        za = (s1_cls_a == CLS_ZERO) || ((DAZ != 0) && (s1_cls_a == CLS_SUBNORM));
        zb = (s1_cls_b == CLS_ZERO) || ((DAZ != 0) && (s1_cls_b == CLS_SUBNORM));
        ia = (s1_cls_a == CLS_INF);
        ib = (s1_cls_b == CLS_INF);
        sa = (s1_cls_a == CLS_SNAN);
        sb = (s1_cls_b == CLS_SNAN);
        na = sa || (s1_cls_a == CLS_QNAN);
        nb = sb || (s1_cls_b == CLS_QNAN);
        if (na || nb) begin
            res_special = 1'b1;
            res_result  = QNAN_VAL;
            res_nv      = sa || sb;
        end else if ((ia && zb) || (ib && za)) begin
            res_special = 1'b1;
            res_result  = QNAN_VAL;
            res_nv      = 1'b1;
        end else if (ia || ib) begin
            res_special = 1'b1;
            res_result  = {s1_sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
            res_inf     = 1'b1;
        end else if (za || zb) begin
            res_special = 1'b1;
            res_result  = {s1_sign, {(WIDTH-1){1'b0}}};
        end
    end

    // Pipeline registers: each stage loads when it is empty or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_cls_a  <= CLS_ZERO;
            s1_cls_b  <= CLS_ZERO;
            s1_sign   <= 1'b0;
            out_valid <= 1'b0;
            special   <= 1'b0;
            result    <= '0;
            sign      <= 1'b0;
            nv        <= 1'b0;
            out_inf   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_cls_a <= cls_a;
                    s1_cls_b <= cls_b;
                    s1_sign  <= a[WIDTH-1] ^ b[WIDTH-1];
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    special <= res_special;
                    result  <= res_result;
                    sign    <= s1_sign;
                    nv      <= res_nv;
                    out_inf <= res_inf;
                end
            end
        end
    end

    // Sticky flags and saturating special counter, updated on output transfer;
    // a clear is applied before the same-cycle event bits are ORed in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags       <= '0;
            special_cnt <= '0;
        end else begin
            if (flag_clr || out_fire) begin
                flags <= (flag_clr ? 2'b00 : flags) | (out_fire ? {nv, out_inf} : 2'b00);
            end
            if (out_fire && special && (special_cnt != '1)) begin
                special_cnt <= special_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_special_pipe.sv
// Directed bench for fp_mul_special_pipe (CNT_WIDTH=2 to reach saturation).
module tb_fp_mul_special_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        special;
    logic [31:0] result;
    logic        sign;
    logic        nv;
    logic [1:0]  flags;
    logic        flag_clr = 1'b0;
    logic [1:0]  special_cnt;

    int checks = 0;
    int failures = 0;

    fp_mul_special_pipe #(.CNT_WIDTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .special     (special),
        .result      (result),
        .sign        (sign),
        .nv          (nv),
        .flags       (flags),
        .flag_clr    (flag_clr),
        .special_cnt (special_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Send one pair into an empty pipe, check the result, latency and the
    // sticky state after the output transfer.
    task automatic op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                      input logic clr, input logic [31:0] e_res, input logic e_sp,
                      input logic e_sign, input logic e_nv, input logic [1:0] e_flags,
                      input logic [1:0] e_cnt);
        int lat;
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        chk({tag, "_latency"}, 32'(lat), 32'd2);
        chk({tag, "_result"}, result, e_res);
        chk({tag, "_special"}, 32'(special), 32'(e_sp));
        chk({tag, "_sign"}, 32'(sign), 32'(e_sign));
        chk({tag, "_nv"}, 32'(nv), 32'(e_nv));
        flag_clr = clr;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        @(negedge clk);
        chk({tag, "_flags"}, 32'(flags), 32'(e_flags));
        chk({tag, "_cnt"}, 32'(special_cnt), 32'(e_cnt));
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    logic [31:0] pa [3];
    logic [31:0] pb [3];
    logic [31:0] pr [3];
    logic [31:0] got [$];
    int          idx;
    logic        acc;
    logic [31:0] held;
    int          seen;

    initial begin
        pa[0] = 32'h7F80_0000; pb[0] = 32'h0000_0000; pr[0] = 32'h7FC0_0000;
        pa[1] = 32'hFF80_0000; pb[1] = 32'h3F80_0000; pr[1] = 32'hFF80_0000;
        pa[2] = 32'h8000_0000; pb[2] = 32'h4000_0000; pr[2] = 32'h8000_0000;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_cnt", 32'(special_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        //  tag     a             b             clr   result        sp    sg    nv    flags  cnt
        op("inf0",  32'h7F80_0000, 32'h0000_0000, 1'b0, 32'h7FC0_0000, 1'b1, 1'b0, 1'b1, 2'b10, 2'd1);
        op("ninf1", 32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 1'b1, 1'b1, 1'b0, 2'b11, 2'd2);
        op("nz2",   32'h8000_0000, 32'h4000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 2'b11, 2'd3);
        op("snan",  32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b1, 1'b0, 1'b1, 2'b11, 2'd3);
        op("norm",  32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b11, 2'd3);
        op("clrinf",32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, 1'b1, 1'b0, 1'b0, 2'b01, 2'd3);
        op("qnan0", 32'h7FC0_0001, 32'h0000_0000, 1'b0, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0, 2'b01, 2'd3);
        op("subinf",32'h0000_0001, 32'hFF80_0000, 1'b0, 32'hFF80_0000, 1'b1, 1'b1, 1'b0, 2'b01, 2'd3);

        // Back-pressure: 4 stalled cycles with continuous input
        out_ready = 1'b0;
        idx = 0;
        held = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) held = result;
            a = pa[idx]; b = pb[idx]; in_valid = 1'b1;
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        @(negedge clk);
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_held", result, held);
        chk("bp_head", result, pr[0]);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 3; c++) begin
            if (idx < 3) begin
                a = pa[idx]; b = pb[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            if (out_valid) got.push_back(result);
            @(posedge clk); #1;
            if (acc) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_order%0d", i), (i < got.size()) ? got[i] : 32'hDEAD_BEEF, pr[i]);
        end

        // Reset with both stages full
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            a = pa[c]; b = pb[c]; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_flags", 32'(flags), 32'd0);
        chk("arst_cnt", 32'(special_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("arst_no_stale", 32'(seen), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_mul_special_pipe.md
FP_MUL_SPECIAL_PIPE -- requirements
Module: fp_mul_special_pipe

Interface
REQ-001 Parameter WIDTH, default 32, total operand width in bits.
REQ-002 Parameter EXP_WIDTH, default 8, exponent field width.
REQ-003 Parameter SIG_WIDTH, default 23, stored fraction width; WIDTH SHALL equal 1+EXP_WIDTH+SIG_WIDTH.
REQ-004 Parameter DAZ, default 0, 1 means subnormal inputs are treated as signed zero.
REQ-005 Parameter CNT_WIDTH, default 16, width of the special-result counter.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 in_valid  input  1  operand pair a/b is valid.
REQ-009 in_ready  output  1  block accepts the pair this cycle.
REQ-010 a, b  input  WIDTH  multiplier operands.
REQ-011 out_valid  output  1  resolved result is valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 special  output  1  result overrides the datapath product.
REQ-014 result  output  WIDTH  override value; all-zero when special=0.
REQ-015 sign  output  1  a[WIDTH-1] XOR b[WIDTH-1].
REQ-016 nv  output  1  invalid-operation flag for this result.
REQ-017 flags  output  2  sticky {invalid, infinite-result}.
REQ-018 flag_clr  input  1  synchronous clear of flags.
REQ-019 special_cnt  output  CNT_WIDTH  saturating count of delivered special results.

Function
REQ-020 Stage 1 SHALL register per-operand class: ZERO, SUBNORM, NORMAL, INF, QNAN, SNAN (QNAN: exp all ones, fraction MSB 1; SNAN: exp all ones, fraction MSB 0, fraction nonzero).
REQ-021 Stage 2 SHALL register resolution; latency in_valid&&in_ready to out_valid SHALL be exactly 2 cycles with no back-pressure.
REQ-022 Any QNAN/SNAN operand SHALL give special=1, result = canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0).
REQ-023 nv=1 when either operand is SNAN, or one is INF and the other is ZERO (or SUBNORM with DAZ=1); INF x ZERO SHALL also give canonical qNaN.
REQ-024 INF x {INF, NORMAL, SUBNORM with DAZ=0} SHALL give infinity with sign per REQ-015.
REQ-025 ZERO (or DAZ subnormal) x finite SHALL give signed zero with sign per REQ-015.
REQ-026 All other pairs SHALL give special=0, result=0, nv=0.
REQ-027 Handshake: transfer occurs when valid&&ready; each stage advances when empty or downstream stage advances; in_ready = !stage1_valid || stage1 advancing.
REQ-028 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; order SHALL be preserved; no drop, no duplicate.
REQ-029 flags and special_cnt SHALL update only on output transfer; flag_clr and a same-cycle transfer: flags <= new-event bits only (clear applied first, new event ORed).
REQ-030 special_cnt SHALL increment by 1 per transferred special=1 result and saturate at all-ones.

Reset
REQ-031 rst_n low SHALL immediately clear both stage valids, out_valid, special, result, sign, nv, flags, special_cnt to 0; in_ready SHALL be 1 after reset release.
REQ-032 Reset mid-operation SHALL discard in-flight pairs; no output transfer follows for them.

Structure
REQ-033 WIDTH/EXP_WIDTH/SIG_WIDTH defaults, the operand-class enumeration and the canonical-qNaN constant SHALL live in the shared FP parameters package.
REQ-034 One sub-module fp_classify (combinational, one operand -> class) SHALL be instantiated twice in stage 1.

Verification
REQ-035 a=0x7F800000, b=0x00000000 -> result 0x7FC00000, special=1, nv=1, flags=2'b10 after transfer.
REQ-036 a=0xFF800000, b=0x3F800000 -> result 0xFF800000, nv=0; a=0x80000000, b=0x40000000 -> result 0x80000000.
REQ-037 a=0x7F800001, b=0x3F800000 -> result 0x7FC00000, nv=1; a=0x3F800000, b=0x40000000 -> special=0, result 0, sign 0.
REQ-038 Back-pressure: out_ready=0 for 4 cycles with in_valid=1 continuous -> exactly 2 pairs accepted then in_ready=0, output held; release -> 3 results in input order.
REQ-039 flag_clr asserted in same cycle as an INF-result transfer -> flags=2'b01; special_cnt with CNT_WIDTH=2 saturates at 3 after 5 special transfers.
REQ-040 rst_n pulsed low with both stages full -> out_valid=0 immediately, no stale result after release.
